// File: rtl/fifo_ring.sv
// rtl/fifo_ring.sv - single-clock ring FIFO with optional recirculate (replay) mode
module fifo_ring #(
  parameter int DEPTH                 = 4,
  parameter int WIDTH                 = 32,
  parameter int FIRSTWORD_FALLTHROUGH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       circular,
  input  logic                       write,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       read,
  output logic [WIDTH-1:0]           dataout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] head_next;
  logic             rd_acc;
  logic             wr_acc;
  logic             recirc;
  logic             push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Accept decisions, tail write data and the head word that will be visible after this edge
  always_comb begin
    rd_acc     = read && !empty;
    // A same-cycle accepted read frees a slot, so a write into a full FIFO still goes in
    wr_acc     = write && (!full || rd_acc);
    // Replay only when no external word claims the tail slot this cycle
    recirc     = circular && rd_acc && !wr_acc;
    push       = wr_acc || recirc;
    wdata      = wr_acc ? datain : mem[rptr];
    rptr_next  = rd_acc ? rptr + AW'(1) : rptr;
    count_next = count + CW'(push) - CW'(rd_acc);
    // The slot being written becomes the head only when it is the sole stored word;
    // bypass it since the array is not updated until this same edge
    head_next  = (push && (wptr == rptr_next)) ? wdata : mem[rptr_next];
  end

  // Storage array: no reset, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      dataout <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      rptr  <= rptr_next;
      count <= count_next;
      if (FIRSTWORD_FALLTHROUGH != 0) begin
        // Show-ahead: keep presenting the head; hold the last word once drained
        if (count_next != '0) begin
          dataout <= head_next;
        end
      end else begin
        if (rd_acc) begin
          dataout <= mem[rptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_ring.sv
// tb/tb_fifo_ring.sv - directed-vector bench for fifo_ring in show-ahead and registered-read forms
module tb_fifo_ring;

  logic        clk;
  logic        reset;

  logic        a_circular, a_write, a_read;
  logic [31:0] a_datain, a_dataout;
  logic        a_full, a_empty;
  logic [2:0]  a_count;

  logic        b_circular, b_write, b_read;
  logic [31:0] b_datain, b_dataout;
  logic        b_full, b_empty;
  logic [2:0]  b_count;

  int vectors;
  int errors;

  fifo_ring #(.DEPTH(4), .WIDTH(32), .FIRSTWORD_FALLTHROUGH(1)) dut_fwft (
    .clk(clk), .reset(reset), .circular(a_circular), .write(a_write), .datain(a_datain),
    .read(a_read), .dataout(a_dataout), .full(a_full), .empty(a_empty), .count(a_count)
  );

  fifo_ring #(.DEPTH(4), .WIDTH(32), .FIRSTWORD_FALLTHROUGH(0)) dut_reg (
    .clk(clk), .reset(reset), .circular(b_circular), .write(b_write), .datain(b_datain),
    .read(b_read), .dataout(b_dataout), .full(b_full), .empty(b_empty), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] d);
    a_write = 1'b1; a_datain = d;
    tick();
    a_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_write = 1'b1; a_datain = 32'h77;
    b_write = 1'b1; b_datain = 32'h77;
    tick(); tick();
    vectors++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", a_empty); end
    vectors++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", a_full); end
    vectors++; if (a_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_count); end
    vectors++; if (a_dataout !== 32'h0) begin errors++; $display("FAIL reset_dataout got %h exp 0", a_dataout); end
    vectors++; if (b_count !== 3'd0) begin errors++; $display("FAIL reset_count_reg got %0d exp 0", b_count); end
    a_write = 1'b0; b_write = 1'b0;
    reset = 1'b1;
    tick();
    vectors++; if (a_count !== 3'd0) begin errors++; $display("FAIL reset_write_ignored got %0d exp 0", a_count); end
  endtask

  task automatic test_fwft_basic();
    push_a(32'h9);
    push_a(32'h1);
    vectors++; if (a_count !== 3'd2) begin errors++; $display("FAIL fwft_count got %0d exp 2", a_count); end
    vectors++; if (a_dataout !== 32'h9) begin errors++; $display("FAIL fwft_head got %h exp 9", a_dataout); end
    a_read = 1'b1;
    tick();
    vectors++; if (a_dataout !== 32'h1) begin errors++; $display("FAIL fwft_second got %h exp 1", a_dataout); end
    tick();
    vectors++; if (a_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty got %0b exp 1", a_empty); end
    vectors++; if (a_dataout !== 32'h1) begin errors++; $display("FAIL fwft_hold got %h exp 1", a_dataout); end
    tick(); tick();
    vectors++; if (a_count !== 3'd0) begin errors++; $display("FAIL fwft_underflow got %0d exp 0", a_count); end
    vectors++; if (a_dataout !== 32'h1) begin errors++; $display("FAIL fwft_underflow_hold got %h exp 1", a_dataout); end
    a_read = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h2; exp_seq[1] = 32'h3; exp_seq[2] = 32'h4; exp_seq[3] = 32'h5;
    for (int i = 0; i < 4; i++) push_a(exp_seq[i]);
    vectors++; if (a_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b exp 1", a_full); end
    vectors++; if (a_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", a_count); end
    push_a(32'h6);
    vectors++; if (a_count !== 3'd4) begin errors++; $display("FAIL ovf_ignored got %0d exp 4", a_count); end
    a_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (a_dataout !== exp_seq[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, a_dataout, exp_seq[i]); end
      tick();
    end
    a_read = 1'b0;
    vectors++; if (a_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %0b exp 1", a_empty); end
    vectors++; if (a_dataout !== 32'h5) begin errors++; $display("FAIL ovf_no_6 got %h exp 5", a_dataout); end
  endtask

  task automatic test_simul_full();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'hB; exp_seq[1] = 32'hC; exp_seq[2] = 32'hD; exp_seq[3] = 32'hE;
    for (int i = 0; i < 4; i++) push_a(32'hA + i);
    vectors++; if (a_full !== 1'b1) begin errors++; $display("FAIL sim_full got %0b exp 1", a_full); end
    a_read = 1'b1; a_write = 1'b1; a_datain = 32'hE;
    tick();
    a_write = 1'b0;
    vectors++; if (a_count !== 3'd4) begin errors++; $display("FAIL sim_count got %0d exp 4", a_count); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (a_dataout !== exp_seq[i]) begin errors++; $display("FAIL sim_order[%0d] got %h exp %h", i, a_dataout, exp_seq[i]); end
      tick();
    end
    a_read = 1'b0;
    vectors++; if (a_empty !== 1'b1) begin errors++; $display("FAIL sim_drained got %0b exp 1", a_empty); end
  endtask

  task automatic test_circular();
    logic [31:0] seq [4];
    seq[0] = 32'hA; seq[1] = 32'hE; seq[2] = 32'h47F; seq[3] = 32'h0;
    for (int i = 0; i < 3; i++) push_a(seq[i]);
    a_circular = 1'b1; a_read = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (a_dataout !== seq[i % 3]) begin errors++; $display("FAIL circ3_data[%0d] got %h exp %h", i, a_dataout, seq[i % 3]); end
      vectors++;
      if (a_count !== 3'd3) begin errors++; $display("FAIL circ3_count[%0d] got %0d exp 3", i, a_count); end
      tick();
    end
    a_read = 1'b0;
    push_a(32'h0);
    vectors++; if (a_count !== 3'd4) begin errors++; $display("FAIL circ_add got %0d exp 4", a_count); end
    a_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (a_dataout !== seq[i % 4]) begin errors++; $display("FAIL circ4_data[%0d] got %h exp %h", i, a_dataout, seq[i % 4]); end
      tick();
    end
    vectors++; if (a_full !== 1'b1) begin errors++; $display("FAIL circ4_full got %0b exp 1", a_full); end
    a_circular = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a_read = 1'b0;
    vectors++; if (a_empty !== 1'b1) begin errors++; $display("FAIL circ_off_drain got %0b exp 1", a_empty); end
  endtask

  task automatic test_nonfwft();
    b_write = 1'b1; b_datain = 32'h55;
    tick();
    b_write = 1'b0;
    vectors++; if (b_dataout !== 32'h0) begin errors++; $display("FAIL nf_before_read got %h exp 0", b_dataout); end
    vectors++; if (b_count !== 3'd1) begin errors++; $display("FAIL nf_count got %0d exp 1", b_count); end
    b_read = 1'b1;
    tick();
    b_read = 1'b0;
    vectors++; if (b_dataout !== 32'h55) begin errors++; $display("FAIL nf_data got %h exp 55", b_dataout); end
    vectors++; if (b_empty !== 1'b1) begin errors++; $display("FAIL nf_empty got %0b exp 1", b_empty); end
    b_write = 1'b1; b_datain = 32'h66;
    tick();
    b_write = 1'b0;
    vectors++; if (b_dataout !== 32'h55) begin errors++; $display("FAIL nf_hold got %h exp 55", b_dataout); end
    b_read = 1'b1;
    tick();
    vectors++; if (b_dataout !== 32'h66) begin errors++; $display("FAIL nf_second got %h exp 66", b_dataout); end
    tick();
    b_read = 1'b0;
    vectors++; if (b_dataout !== 32'h66) begin errors++; $display("FAIL nf_empty_read got %h exp 66", b_dataout); end
  endtask

  initial begin
    vectors = 0; errors = 0;
    reset = 1'b0;
    a_circular = 1'b0; a_write = 1'b0; a_read = 1'b0; a_datain = '0;
    b_circular = 1'b0; b_write = 1'b0; b_read = 1'b0; b_datain = '0;
    test_reset();
    test_fwft_basic();
    test_overflow();
    test_simul_full();
    test_circular();
    test_nonfwft();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ring.md
Name: fifo_ring

Overview:
- Synchronous single-clock FIFO with word-wide data, full/empty flags and an occupancy count.
- Adds a circular (recirculate) mode in which read words are re-queued at the tail, so stored contents replay indefinitely.
- Used as a generic buffering primitive between producer and consumer blocks sharing one clock.

Parameters:
- DEPTH, 4, number of storage words; power of two, at least 2.
- WIDTH, 32, data word width in bits.
- FIRSTWORD_FALLTHROUGH, 1, 1 = head word is visible on dataout before read (show-ahead); 0 = dataout loads one cycle after an accepted read.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- circular  input  1  1 = an accepted read re-enqueues the read word at the tail.
- write  input  1  write request.
- datain  input  WIDTH  write data.
- read  input  1  read request / acknowledge.
- dataout  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  number of stored words.

Behaviour:
- Reset (reset low at a clk edge): pointers = 0, count = 0, empty = 1, full = 0, dataout = 0. Memory contents need not be cleared. Reset dominates all other inputs.
- Storage: DEPTH-entry array; read and write pointers of width $clog2(DEPTH), each wrapping from DEPTH-1 to 0.
- Write accept: write=1 and (full=0, or a read is accepted in the same cycle). The word is stored at wptr and wptr increments.
- Write to a full FIFO with no accepted read: ignored; no state change.
- Read accept: read=1 and empty=0. rptr increments. Read on empty is ignored: no underflow, dataout holds.
- Read and write in the same cycle, FIFO non-empty: both accepted; count unchanged. This also applies when full.
- Read and write in the same cycle, FIFO empty: only the write is accepted.
- Circular mode (circular=1):
  - An accepted read with no accepted write writes the read word back at wptr and increments both pointers. Count is unchanged.
  - An accepted read plus external write in the same cycle: the external datain is stored and the read word is discarded (normal FIFO behaviour).
  - Toggling circular takes effect on the next edge; contents are preserved.
- FIRSTWORD_FALLTHROUGH=1:
  - dataout is registered and shows the head word whenever empty=0.
  - The first word written into an empty FIFO appears on dataout the cycle after its write edge.
  - After an accepted read, dataout shows the next head word on the following cycle.
  - When the FIFO goes empty, dataout holds the last presented word.
- FIRSTWORD_FALLTHROUGH=0:
  - dataout is loaded with mem[rptr] on the edge that accepts a read, so data is valid one cycle after the read request.
  - dataout holds otherwise.
- Flags: full and empty are derived from the registered count and update on the same edge as count. count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset: hold reset low 2 cycles -> empty=1, full=0, count=0, dataout=0. Write during reset -> ignored.
- FWFT basic (FIRSTWORD_FALLTHROUGH=1): write 0x9 then 0x1 -> count=2, dataout=0x9 before any read. Read 1 cycle -> dataout=0x1. Read again -> empty=1, dataout stays 0x1. Further reads -> count stays 0.
- Full/overflow: write 0x2,0x3,0x4,0x5 -> full=1, count=4. Write 0x6 with read=0 -> ignored. Read 4 times -> outputs 0x2,0x3,0x4,0x5; 0x6 is never seen.
- Simultaneous at full: full with 0xA..0xD; read=1, write=1, datain=0xE -> count stays 4. Output order continues 0xB,0xC,0xD,0xE.
- Circular replay: write 0xA, 0xE, 0x47F. Set circular=1 and hold read 12 cycles -> dataout cycles 0xA,0xE,0x47F repeatedly (4 full rotations), count=3 throughout. Then write 0x0 with read=0 -> count=4. Continued reads include 0x0 in the rotation.
- Non-FWFT latency (FIRSTWORD_FALLTHROUGH=0): write 0x55 -> dataout remains 0. Pulse read -> dataout=0x55 one cycle later, empty=1.
